// File: rtl/uart_pkg.sv
// Shared constants and capture-FSM state type for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    WAIT = 2'd2
  } cap_state_e;
endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_LVL   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  rd_ok, wr_ok;

  assign full     = (level_q == DEPTH_LVL);
  assign rd_valid = (level_q != '0);
  assign level    = level_q;
  assign rd_data  = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign rd_ok = rd_en && rd_valid;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + ONE_PTR : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + ONE_PTR : rd_ptr_q;
    level_d  = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Drains the UART receiver holding register into a byte FIFO, issuing one
// rdy_clr pulse per received byte and tracking sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                rx_rdy,
  input  logic [DATA_W-1:0]   rx_data,
  output logic                rx_rdy_clr,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                ovf_clr
);
  cap_state_e state_q, state_d;
  logic       cap_wr;
  logic       rx_rdy_clr_q, rx_rdy_clr_d;
  logic       overflow_q, overflow_d;
  logic       drop;

  always_comb begin
    state_d = state_q;
    cap_wr  = 1'b0;
    case (state_q)
      IDLE: if (rx_rdy) begin
        cap_wr  = 1'b1;
        state_d = CLR;
      end
      CLR:  state_d = WAIT;
      WAIT: if (!rx_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte is lost only when full and nothing leaves on the same edge.
  assign drop         = cap_wr && full && !rd_en;
  assign rx_rdy_clr_d = (state_d == CLR);
  assign overflow_d   = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_rdy_clr_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_rdy_clr_q <= rx_rdy_clr_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rx_rdy_clr = rx_rdy_clr_q;
  assign overflow   = overflow_q;

  byte_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk_50m),
    .rst      (rst),
    .wr_en    (cap_wr),
    .wr_data  (rx_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .level    (level)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, handshake, full/overflow, wrap-around.
module tb_uart_rx_fifo;
  logic       clk_50m = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr;

  int n_total = 0;
  int n_bad   = 0;

  always #10 clk_50m = ~clk_50m;

  uart_rx_fifo dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  // Three-cycle receive: capture edge, CLR->WAIT edge, WAIT->IDLE edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rx_rdy  = 1'b0;
    step();
    step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  logic [7:0] q[$];
  int         pulses;
  logic [7:0] hd;

  initial begin
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'h11; rd_en = 1'b0; ovf_clr = 1'b0;

    // 1: reset held two cycles with rx_rdy high
    for (int c = 0; c < 2; c++) begin
      step();
      check_eq("rst_clr",  32'(rx_rdy_clr), 32'd0);
      check_eq("rst_lvl",  32'(level),      32'd0);
      check_eq("rst_vld",  32'(rd_valid),   32'd0);
      check_eq("rst_full", 32'(full),       32'd0);
      check_eq("rst_ovf",  32'(overflow),   32'd0);
    end
    rst = 1'b0;
    step();
    check_eq("post_rst_clr",  32'(rx_rdy_clr), 32'd1);
    check_eq("post_rst_lvl",  32'(level),      32'd1);
    check_eq("post_rst_data", 32'(rd_data),    32'h11);
    rx_rdy = 1'b0;
    step();
    check_eq("post_rst_clr_off", 32'(rx_rdy_clr), 32'd0);
    step();
    check_eq("post_rst_lvl_once", 32'(level), 32'd1);
    pop();
    check_eq("post_rst_drained", 32'(level), 32'd0);

    // 2: single byte latency and pop
    rx_data = 8'hA5; rx_rdy = 1'b1;
    step();
    check_eq("a5_clr",  32'(rx_rdy_clr), 32'd1);
    check_eq("a5_vld",  32'(rd_valid),   32'd1);
    check_eq("a5_data", 32'(rd_data),    32'hA5);
    check_eq("a5_lvl",  32'(level),      32'd1);
    rx_rdy = 1'b0;
    step();
    check_eq("a5_clr_off", 32'(rx_rdy_clr), 32'd0);
    step();
    pop();
    check_eq("a5_pop_lvl", 32'(level),    32'd0);
    check_eq("a5_pop_vld", 32'(rd_valid), 32'd0);

    // 3: rx_rdy held long -> one write, one pulse
    rx_data = 8'h3C; rx_rdy = 1'b1; pulses = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      pulses += int'(rx_rdy_clr);
    end
    rx_rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      pulses += int'(rx_rdy_clr);
    end
    check_eq("hold_pulses", 32'(pulses),  32'd1);
    check_eq("hold_lvl",    32'(level),   32'd1);
    check_eq("hold_data",   32'(rd_data), 32'h3C);
    pop();

    // 4: fill, overflow, drain in order, ovf_clr, set-wins
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check_eq("fill_full", 32'(full),  32'd1);
    check_eq("fill_lvl",  32'(level), 32'd16);
    rx_data = 8'hFF; rx_rdy = 1'b1;
    step();
    check_eq("drop_clr", 32'(rx_rdy_clr), 32'd1);
    check_eq("drop_ovf", 32'(overflow),   32'd1);
    check_eq("drop_lvl", 32'(level),      32'd16);
    rx_rdy = 1'b0;
    step(); step();
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
      pop();
    end
    check_eq("drain_lvl", 32'(level),    32'd0);
    check_eq("drain_ovf", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
    rx_data = 8'hDD; rx_rdy = 1'b1; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0; rx_rdy = 1'b0;
    check_eq("set_wins_ovf", 32'(overflow), 32'd1);
    step(); step();

    // 5: full FIFO, write and pop on the same edge
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("pre5_ovf", 32'(overflow), 32'd0);
    rx_data = 8'hEE; rx_rdy = 1'b1; rd_en = 1'b1;
    step();
    rd_en = 1'b0; rx_rdy = 1'b0;
    check_eq("swp_lvl", 32'(level),    32'd16);
    check_eq("swp_ovf", 32'(overflow), 32'd0);
    step(); step();
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("swp_rd_%0d", i), 32'(rd_data), 32'(8'h20 + i));
      pop();
    end
    check_eq("swp_last", 32'(rd_data), 32'hEE);
    pop();
    check_eq("swp_empty", 32'(level), 32'd0);

    // 6: wrap-around with interleaved pops against a queue
    q.delete();
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(8'h10 + i); rx_rdy = 1'b1;
      step();
      q.push_back(8'(8'h10 + i));
      check_eq($sformatf("wrap_lvl_w%0d", i), 32'(level), 32'(q.size()));
      rx_rdy = 1'b0;
      if (q.size() >= 5 || (i % 3) == 2) begin
        check_eq($sformatf("wrap_rd_%0d", i), 32'(rd_data), 32'(q[0]));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        hd = q.pop_front();
      end else begin
        step();
      end
      check_eq($sformatf("wrap_lvl_p%0d", i), 32'(level), 32'(q.size()));
      step();
      check_eq($sformatf("wrap_lvl_i%0d", i), 32'(level), 32'(q.size()));
    end
    while (q.size() > 0) begin
      check_eq("wrap_tail", 32'(rd_data), 32'(q[0]));
      pop();
      hd = q.pop_front();
      check_eq("wrap_tail_lvl", 32'(level), 32'(q.size()));
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("empty_pop_lvl", 32'(level),    32'd0);
    check_eq("empty_pop_vld", 32'(rd_valid), 32'd0);
    check_eq("empty_pop_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
